// File: rtl/fir_mac.sv
// Sequential single-multiplier FIR filter with a writable coefficient file and a rounded, saturated output.
// Optional build macro FIR_SYM_EN selects the symmetric (pre-added, half-length) coefficient variant.
module fir_mac #(
  parameter int DW   = 16,
  parameter int CW   = 16,
  parameter int TAPS = 32,
  parameter int FRAC = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DW-1:0]           data,
  input  logic                    data_valid,
  output logic                    data_ready,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [CW-1:0]           coef_wdata,
  output logic [DW-1:0]           fir_d,
  output logic                    fir_valid,
  output logic                    busy
);

  localparam int AB = $clog2(TAPS);
  localparam int AW = DW + CW + AB;
  localparam int CB = $clog2(TAPS + 1);
`ifdef FIR_SYM_EN
  localparam int NCOEF = TAPS / 2;
  localparam int XW    = DW + 1;
`else
  localparam int NCOEF = TAPS;
  localparam int XW    = DW;
`endif
  localparam int NB = (NCOEF > 1) ? $clog2(NCOEF) : 1;
  localparam int PW = XW + CW;

  localparam logic signed [AW:0] ROUND_HALF = (AW + 1)'(1) <<< (FRAC - 1);
  localparam logic signed [AW:0] SAT_MAX = {{(AW + 2 - DW){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic signed [AW:0] SAT_MIN = {{(AW + 2 - DW){1'b1}}, {(DW - 1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t                r_state;
  logic signed [DW-1:0]  r_hist [TAPS];
  logic signed [CW-1:0]  r_coef [NCOEF];
  logic [AB-1:0]         r_ptr;
  logic [AB-1:0]         r_rd_new;
  logic [NB-1:0]         r_tap;
  logic [CB-1:0]         r_cnt;
  logic signed [AW-1:0]  r_acc;
  logic [DW-1:0]         r_fir_d;
  logic                  r_fir_valid;
  logic                  r_ready;
  logic                  r_busy;

  logic signed [XW-1:0]  w_x;
  logic signed [PW-1:0]  w_prod;
  logic signed [AW:0]    w_round;
  logic signed [AW:0]    w_shift;
  logic [DW-1:0]         w_sat;

  function automatic logic [AB-1:0] wrap_inc(input logic [AB-1:0] i);
    return (i == AB'(TAPS - 1)) ? '0 : i + AB'(1);
  endfunction

  function automatic logic [AB-1:0] wrap_dec(input logic [AB-1:0] i);
    return (i == '0) ? AB'(TAPS - 1) : i - AB'(1);
  endfunction

`ifdef FIR_SYM_EN
  // Second read pointer walks forward from the oldest sample to pair x[n-k] with x[n-(TAPS-1-k)].
  logic [AB-1:0] r_rd_old;
  assign w_x = XW'(r_hist[r_rd_new]) + XW'(r_hist[r_rd_old]);
`else
  assign w_x = r_hist[r_rd_new];
`endif

  assign w_prod  = PW'(w_x) * PW'(r_coef[r_tap]);
  assign w_round = {r_acc[AW-1], r_acc} + ROUND_HALF;
  assign w_shift = w_round >>> FRAC;

  // NOTE: give every always_comb output a default first so no path leaves it unassigned (latch).
  always_comb begin
    w_sat = w_shift[DW-1:0];
    if (w_shift > SAT_MAX)      w_sat = {1'b0, {(DW - 1){1'b1}}};
    else if (w_shift < SAT_MIN) w_sat = {1'b1, {(DW - 1){1'b0}}};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: history and coefficients are ordinary flops here and must come out of reset cleared.
      for (int i = 0; i < TAPS; i++)  r_hist[i] <= '0;
      for (int i = 0; i < NCOEF; i++) r_coef[i] <= '0;
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_rd_new    <= '0;
`ifdef FIR_SYM_EN
      r_rd_old    <= '0;
`endif
      r_tap       <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_fir_d     <= '0;
      r_fir_valid <= 1'b0;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_fir_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (coef_we && (32'(coef_addr) < NCOEF)) r_coef[coef_addr[NB-1:0]] <= coef_wdata;
          if (data_valid) begin
            r_hist[r_ptr] <= data;
            r_rd_new      <= r_ptr;
`ifdef FIR_SYM_EN
            r_rd_old      <= wrap_inc(r_ptr);
`endif
            r_ptr         <= wrap_inc(r_ptr);
            r_acc         <= '0;
            r_tap         <= '0;
            if (r_cnt != CB'(TAPS)) r_cnt <= r_cnt + CB'(1);
            r_state       <= S_MAC;
            r_ready       <= 1'b0;
            r_busy        <= 1'b1;
          end
        end
        S_MAC: begin
          r_acc    <= r_acc + AW'(w_prod);
          r_rd_new <= wrap_dec(r_rd_new);
`ifdef FIR_SYM_EN
          r_rd_old <= wrap_inc(r_rd_old);
`endif
          r_tap    <= r_tap + NB'(1);
          if (r_tap == NB'(NCOEF - 1)) r_state <= S_OUT;
        end
        S_OUT: begin
          // Output updates even during warm-up; only the valid strobe waits for a full window.
          r_fir_d     <= w_sat;
          r_fir_valid <= (r_cnt == CB'(TAPS));
          r_state     <= S_IDLE;
          r_ready     <= 1'b1;
          r_busy      <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data_ready = r_ready;
  assign busy       = r_busy;
  assign fir_d      = r_fir_d;
  assign fir_valid  = r_fir_valid;

endmodule

// File: tb/tb_fir_mac.sv
// Scoreboard bench for fir_mac (DW=16, CW=16, TAPS=32, FRAC=16, full-length build).
// Stimulus pushes hand-computed outputs into a queue; a negedge monitor pops one per fir_valid pulse.
module tb_fir_mac;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] data = '0;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic        coef_we = 1'b0;
  logic [4:0]  coef_addr = '0;
  logic [15:0] coef_wdata = '0;
  logic [15:0] fir_d;
  logic        fir_valid;
  logic        busy;

  int          n_checks = 0;
  int          n_errors = 0;
  int          valid_seen = 0;
  int          cyc = 0;
  logic [15:0] exp_q [$];

  fir_mac #(.DW(16), .CW(16), .TAPS(32), .FRAC(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .fir_d      (fir_d),
    .fir_valid  (fir_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (fir_valid === 1'b1) begin
      valid_seen++;
      if (exp_q.size() == 0) check("unexpected_fir_valid", 32'(fir_valid), 32'd0);
      else                   check("fir_d", 32'(fir_d), 32'(exp_q.pop_front()));
    end
  end

  // Returns at a negedge with data_ready high, or logs a timeout.
  task automatic wait_ready(input string name);
    int n = 0;
    @(negedge clk);
    while (data_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (data_ready !== 1'b1) check({name, "_timeout"}, 32'(data_ready), 32'd1);
  endtask

  task automatic send(input logic [15:0] s, input bit expect_out, input logic [15:0] e);
    wait_ready("send");
    data       = s;
    data_valid = 1'b1;
    if (expect_out) exp_q.push_back(e);
    @(posedge clk);
    #1 data_valid = 1'b0;
  endtask

  task automatic write_coef(input logic [4:0] a, input logic [15:0] v);
    wait_ready("coef");
    coef_we    = 1'b1;
    coef_addr  = a;
    coef_wdata = v;
    @(posedge clk);
    #1 coef_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    data_valid = 1'b0;
    coef_we    = 1'b0;
    rst        = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int lat;
    int acc_cyc [3];
    int na;
    int n;
    int first_n;
    int seen0;

    // Reset state
    do_reset();
    check("rst_data_ready", 32'(data_ready), 32'd1);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_fir_valid",  32'(fir_valid),  32'd0);
    check("rst_fir_d",      32'(fir_d),      32'd0);

    // Impulse, warm-up and latency
    for (int k = 0; k < 32; k++) write_coef(5'(k), 16'h4000);
    for (int k = 0; k < 31; k++) send(16'h0000, 1'b0, 16'h0);
    wait_ready("warmup");
    check("warmup_no_valid", 32'(valid_seen), 32'd0);
    send(16'h0000, 1'b1, 16'h0000);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (fir_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    check("latency_cycles", 32'(lat), 32'd34);
    send(16'h1000, 1'b1, 16'h0400);
    for (int k = 0; k < 31; k++) send(16'h0000, 1'b1, 16'h0400);
    send(16'h0000, 1'b1, 16'h0000);
    wait_ready("impulse_end");

    // Saturation, positive then negative
    do_reset();
    for (int k = 0; k < 32; k++) write_coef(5'(k), 16'h7FFF);
    for (int k = 0; k < 31; k++) send(16'h7FFF, 1'b0, 16'h0);
    send(16'h7FFF, 1'b1, 16'h7FFF);
    wait_ready("sat_pos_end");
    do_reset();
    for (int k = 0; k < 32; k++) write_coef(5'(k), 16'h7FFF);
    for (int k = 0; k < 31; k++) send(16'h8000, 1'b0, 16'h0);
    send(16'h8000, 1'b1, 16'h8000);
    wait_ready("sat_neg_end");

    // Rounding: half LSB rounds toward +inf
    do_reset();
    write_coef(5'd0, 16'h0001);
    for (int k = 0; k < 31; k++) send(16'h0000, 1'b0, 16'h0);
    send(16'h8000, 1'b1, 16'h0000);
    send(16'h7FFF, 1'b1, 16'h0000);
    write_coef(5'd0, 16'h0002);
    send(16'h8000, 1'b1, 16'hFFFF);
    send(16'h4000, 1'b1, 16'h0001);
    send(16'hC000, 1'b1, 16'h0000);
    send(16'h4000, 1'b1, 16'h0001);
    wait_ready("round_end");
    repeat (10) @(negedge clk);
    check("fir_d_hold", 32'(fir_d), 32'h0001);

    // Contention: data_valid held high, coef_we attempted while busy
    wait_ready("cont_start");
    data       = 16'h4000;
    data_valid = 1'b1;
    na = 0;
    n  = 0;
    first_n = 0;
    while (na < 3 && n < 200) begin
      if (data_ready === 1'b1) begin
        acc_cyc[na] = cyc;
        if (na == 0) first_n = n;
        na++;
        exp_q.push_back(16'h0001);
      end
      coef_we    = (na == 1) && (n - first_n >= 3) && (n - first_n <= 7);
      coef_addr  = 5'd0;
      coef_wdata = 16'h1000;
      @(negedge clk);
      n++;
    end
    data_valid = 1'b0;
    coef_we    = 1'b0;
    check("cont_accepts", 32'(na), 32'd3);
    check("cont_spacing_1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd34);
    check("cont_spacing_2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd34);
    send(16'h4000, 1'b1, 16'h0001);
    wait_ready("cont_end");

    // Reset at MAC cycle 10 aborts the computation and restarts warm-up
    send(16'h4000, 1'b0, 16'h0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_data_ready", 32'(data_ready), 32'd1);
    check("midrst_busy",       32'(busy),       32'd0);
    check("midrst_fir_valid",  32'(fir_valid),  32'd0);
    check("midrst_fir_d",      32'(fir_d),      32'd0);
    seen0 = valid_seen;
    repeat (40) @(negedge clk);
    check("midrst_no_valid", 32'(valid_seen - seen0), 32'd0);
    write_coef(5'd0, 16'h0002);
    for (int k = 0; k < 31; k++) send(16'h4000, 1'b0, 16'h0);
    wait_ready("restart_warm");
    check("restart_no_valid", 32'(valid_seen - seen0), 32'd0);
    check("restart_fir_d_updates", 32'(fir_d), 32'h0001);
    send(16'h4000, 1'b1, 16'h0001);
    wait_ready("final");
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
